// File: rtl/btn_event_if.sv
// Event port bundle between the button event scheduler and the UI consumer.
// master = scheduler side, slave = consumer/stimulus side.
interface btn_event_if #(
    parameter int N_BTN  = 4,
    parameter int CHAN_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
);
    logic [N_BTN-1:0]  db_in;
    logic              evt_valid;
    logic              evt_ready;
    logic [CHAN_W-1:0] evt_chan;
    logic [1:0]        evt_code;
    logic [N_BTN-1:0]  ovf;
    logic [N_BTN-1:0]  ovf_clr;

    modport master (
        input  db_in, evt_ready, ovf_clr,
        output evt_valid, evt_chan, evt_code, ovf
    );

    modport slave (
        output db_in, evt_ready, ovf_clr,
        input  evt_valid, evt_chan, evt_code, ovf
    );
endinterface

// File: rtl/btn_event_ctrl.sv
// Classifies debounced button levels into PRESS/RELEASE/LONG/REPEAT events and
// funnels them through one round-robin arbitrated valid/ready port.
//   state   | meaning
//   IDLE    | button released, waiting for press
//   PRESSED | pressed, hold timer counting down to LONG
//   HELD    | LONG issued, repeat timer counting down to each REPEAT
module btn_event_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int N_BTN       = 4,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic       clk,
    input  logic       rst,
    btn_event_if.master bus
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int CW       = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_state_t;

    logic [TW-1:0] presc;
    logic          ms_tick;

    assign ms_tick = (presc == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || ms_tick) presc <= '0;
        else                presc <= presc + TW'(1);
    end

    btn_state_t               state_q [N_BTN];
    btn_state_t               state_d [N_BTN];
    logic [N_BTN-1:0][15:0]   hold_q, hold_d;
    logic [N_BTN-1:0][15:0]   rep_q, rep_d;
    logic [N_BTN-1:0]         raise;
    logic [N_BTN-1:0][1:0]    raise_code;

    // Timers are down-counters: loaded with the full interval and firing when a
    // tick arrives at a count of 1, which matches an up-count reaching the limit.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]    = state_q[i];
            hold_d[i]     = hold_q[i];
            rep_d[i]      = rep_q[i];
            raise[i]      = 1'b0;
            raise_code[i] = EV_PRESS;
            case (state_q[i])
                IDLE: begin
                    if (bus.db_in[i]) begin
                        state_d[i] = PRESSED;
                        raise[i]   = 1'b1;
                        hold_d[i]  = 16'(LONG_MS);
                    end
                end
                PRESSED: begin
                    if (!bus.db_in[i]) begin
                        state_d[i]    = IDLE;
                        raise[i]      = 1'b1;
                        raise_code[i] = EV_RELEASE;
                    end else if (ms_tick) begin
                        if (hold_q[i] == 16'd1) begin
                            state_d[i]    = HELD;
                            raise[i]      = 1'b1;
                            raise_code[i] = EV_LONG;
                            rep_d[i]      = 16'(REPEAT_MS);
                        end else begin
                            hold_d[i] = hold_q[i] - 16'd1;
                        end
                    end
                end
                HELD: begin
                    if (!bus.db_in[i]) begin
                        state_d[i]    = IDLE;
                        raise[i]      = 1'b1;
                        raise_code[i] = EV_RELEASE;
                    end else if (ms_tick) begin
                        if (rep_q[i] == 16'd1) begin
                            raise[i]      = 1'b1;
                            raise_code[i] = EV_REPEAT;
                            rep_d[i]      = 16'(REPEAT_MS);
                        end else begin
                            rep_d[i] = rep_q[i] - 16'd1;
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (rst) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
                rep_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                rep_q[i]   <= rep_d[i];
            end
        end
    end

    logic [N_BTN-1:0]      pend_vld;
    logic [N_BTN-1:0][1:0] pend_code;
    logic [N_BTN-1:0]      grant;
    logic [N_BTN-1:0]      drop;
    logic [CW-1:0]         ptr;
    logic [CW-1:0]         sel;
    logic                  found;
    logic                  load;

    assign load = !bus.evt_valid || bus.evt_ready;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!found && pend_vld[(int'(ptr) + k) % N_BTN]) begin
                found = 1'b1;
                sel   = CW'((int'(ptr) + k) % N_BTN);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (load && found) grant[sel] = 1'b1;
    end

    assign drop = raise & pend_vld & ~grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= '0;
            pend_code <= '0;
            bus.ovf   <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (raise[i] && (!pend_vld[i] || grant[i])) begin
                    pend_vld[i]  <= 1'b1;
                    pend_code[i] <= raise_code[i];
                end else if (grant[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
            bus.ovf <= (bus.ovf & ~bus.ovf_clr) | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.evt_valid <= 1'b0;
            bus.evt_chan  <= '0;
            bus.evt_code  <= '0;
            ptr           <= '0;
        end else if (load) begin
            bus.evt_valid <= found;
            if (found) begin
                bus.evt_chan <= sel;
                bus.evt_code <= pend_code[sel];
                ptr          <= sel;
            end
        end
    end
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: event-level reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized traffic.
module tb_btn_event_ctrl;
    localparam int CLK_FREQ_HZ = 8000;
    localparam int TICK_DIV    = CLK_FREQ_HZ / 1000;
    localparam int N_BTN       = 4;
    localparam int LONG_MS     = 5;
    localparam int REPEAT_MS   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] db;
    logic [N_BTN-1:0] ovf_clr;
    logic             evt_ready;

    btn_event_if #(.N_BTN(N_BTN)) bus ();

    assign bus.db_in     = db;
    assign bus.evt_ready = evt_ready;
    assign bus.ovf_clr   = ovf_clr;

    btn_event_ctrl #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .N_BTN      (N_BTN),
        .LONG_MS    (LONG_MS),
        .REPEAT_MS  (REPEAT_MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc_t   = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_t);
    endtask

    // Reference model: each channel is "pressed or not" plus a count of ms
    // ticks seen while pressed; events follow directly from that count.
    int               m_cyc;
    bit               m_pr [N_BTN];
    int               m_tk [N_BTN];
    bit               m_pv [N_BTN];
    int               m_pc [N_BTN];
    logic [N_BTN-1:0] m_ovf;
    bit               m_valid;
    int               m_chan, m_code, m_ptr;

    always @(posedge clk) begin
        int g, gcode, code, c;
        bit ld, tick, rs;
        logic [N_BTN-1:0] dr;
        cyc_t++;
        if (rst) begin
            m_cyc = 0; m_ovf = '0; m_valid = 0; m_chan = 0; m_code = 0; m_ptr = 0;
            for (int i = 0; i < N_BTN; i++) begin
                m_pr[i] = 0; m_tk[i] = 0; m_pv[i] = 0; m_pc[i] = 0;
            end
        end else begin
            m_cyc++;
            tick = (m_cyc % TICK_DIV) == 0;
            ld = !m_valid || evt_ready;
            g = -1; gcode = 0;
            if (ld) begin
                for (int k = 1; k <= N_BTN; k++) begin
                    c = (m_ptr + k) % N_BTN;
                    if (g < 0 && m_pv[c]) begin g = c; gcode = m_pc[c]; end
                end
            end
            dr = '0;
            for (int i = 0; i < N_BTN; i++) begin
                rs = 0; code = 0;
                if (!m_pr[i]) begin
                    if (db[i]) begin rs = 1; code = 0; m_pr[i] = 1; m_tk[i] = 0; end
                end else if (!db[i]) begin
                    rs = 1; code = 1; m_pr[i] = 0;
                end else if (tick) begin
                    m_tk[i]++;
                    if (m_tk[i] == LONG_MS) begin rs = 1; code = 2; end
                    else if (m_tk[i] > LONG_MS && (m_tk[i] - LONG_MS) % REPEAT_MS == 0) begin rs = 1; code = 3; end
                end
                if (rs) begin
                    if (!m_pv[i] || g == i) begin m_pv[i] = 1; m_pc[i] = code; end
                    else dr[i] = 1'b1;
                end else if (g == i) begin
                    m_pv[i] = 0;
                end
            end
            m_ovf = (m_ovf & ~ovf_clr) | dr;
            if (ld) begin
                m_valid = (g >= 0);
                if (g >= 0) begin m_chan = g; m_code = gcode; m_ptr = g; end
            end
        end
    end

    typedef struct { int chan; int code; int t; } ev_t;
    ev_t log_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("evt_valid", bus.evt_valid, m_valid);
            if (m_valid) begin
                chk("evt_chan", bus.evt_chan, m_chan);
                chk("evt_code", bus.evt_code, m_code);
            end
            chk("ovf", bus.ovf, m_ovf);
        end
        if (bus.evt_valid === 1'b1 && evt_ready === 1'b1)
            log_q.push_back('{chan: int'(bus.evt_chan), code: int'(bus.evt_code), t: cyc_t});
    end

    function automatic ev_t get_ev(input int idx);
        ev_t e;
        e.chan = -1; e.code = -1; e.t = -1;
        if (idx < log_q.size()) e = log_q[idx];
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base, c0, c1, d;
        ev_t e;
        rst = 1'b1; db = '0; ovf_clr = '0; evt_ready = 1'b1;
        step(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_valid", bus.evt_valid, 0);
        chk("rst_chan", bus.evt_chan, 0);
        chk("rst_code", bus.evt_code, 0);
        chk("rst_ovf", bus.ovf, 0);
        step(3);

        // short press on ch1
        base = log_q.size(); c0 = cyc_t;
        db[1] = 1'b1; step(20);
        c1 = cyc_t; db[1] = 1'b0; step(5);
        chk("sp_count", log_q.size() - base, 2);
        e = get_ev(base);
        chk("sp_press_chan", e.chan, 1); chk("sp_press_code", e.code, 0); chk("sp_press_lat", e.t - c0, 2);
        e = get_ev(base + 1);
        chk("sp_rel_chan", e.chan, 1); chk("sp_rel_code", e.code, 1); chk("sp_rel_lat", e.t - c1, 2);

        // long hold with repeats on ch2
        base = log_q.size(); c0 = cyc_t;
        db[2] = 1'b1; step(80);
        c1 = cyc_t; db[2] = 1'b0; step(5);
        chk("lh_count", log_q.size() - base, 5);
        for (int i = 0; i < 5; i++) chk("lh_chan", get_ev(base + i).chan, 2);
        chk("lh_code0", get_ev(base).code, 0);
        chk("lh_code1", get_ev(base + 1).code, 2);
        chk("lh_code2", get_ev(base + 2).code, 3);
        chk("lh_code3", get_ev(base + 3).code, 3);
        chk("lh_code4", get_ev(base + 4).code, 1);
        chk("lh_press_lat", get_ev(base).t - c0, 2);
        d = get_ev(base + 1).t - get_ev(base).t;
        chk("lh_long_window", (d >= 33 && d <= 40), 1);
        chk("lh_rep_gap1", get_ev(base + 2).t - get_ev(base + 1).t, 16);
        chk("lh_rep_gap2", get_ev(base + 3).t - get_ev(base + 2).t, 16);
        chk("lh_rel_lat", get_ev(base + 4).t - c1, 2);

        // simultaneous press after reset: order 1,2,3,0
        rst = 1'b1; step(1); rst = 1'b0; step(2);
        base = log_q.size(); c0 = cyc_t;
        db = 4'hF; step(8);
        db = 4'h0; step(8);
        chk("sim_count", log_q.size() - base, 8);
        chk("sim_ch_a", get_ev(base).chan, 1);
        chk("sim_ch_b", get_ev(base + 1).chan, 2);
        chk("sim_ch_c", get_ev(base + 2).chan, 3);
        chk("sim_ch_d", get_ev(base + 3).chan, 0);
        for (int i = 0; i < 4; i++) begin
            chk("sim_code", get_ev(base + i).code, 0);
            chk("sim_time", get_ev(base + i).t - c0, 2 + i);
        end

        // backpressure and overflow on ch0
        evt_ready = 1'b0;
        base = log_q.size();
        db[0] = 1'b1; step(2);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.evt_valid, 1);
            chk("bp_chan", bus.evt_chan, 0);
            chk("bp_code", bus.evt_code, 0);
            step(1);
        end
        db[0] = 1'b0; step(2);
        db[0] = 1'b1; step(2);
        chk("bp_ovf_set", bus.ovf, 4'b0001);
        evt_ready = 1'b1; step(4);
        chk("bp_count", log_q.size() - base, 2);
        chk("bp_first_code", get_ev(base).code, 0);
        chk("bp_second_code", get_ev(base + 1).code, 1);
        chk("bp_second_chan", get_ev(base + 1).chan, 0);
        ovf_clr = 4'b0001; step(1); ovf_clr = '0;
        chk("bp_ovf_clr", bus.ovf, 0);
        db[0] = 1'b0; step(4);

        // reset mid-hold on ch3, with an overflow pending beforehand
        evt_ready = 1'b0;
        db[3] = 1'b1; step(2);
        db[0] = 1'b1; step(2);
        db[0] = 1'b0; step(2);
        step(24);
        chk("rh_ovf_before", bus.ovf, 4'b0001);
        c0 = cyc_t;
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rh_valid_after", bus.evt_valid, 0);
        chk("rh_ovf_after", bus.ovf, 0);
        evt_ready = 1'b1;
        base = log_q.size();
        step(50);
        chk("rh_count", log_q.size() - base, 2);
        chk("rh_press_chan", get_ev(base).chan, 3);
        chk("rh_press_code", get_ev(base).code, 0);
        chk("rh_press_t", get_ev(base).t - c0, 3);
        chk("rh_long_code", get_ev(base + 1).code, 2);
        chk("rh_long_t", get_ev(base + 1).t - c0, 42);
        db[3] = 1'b0; step(6);

        // grant and raise collide on ch1
        base = log_q.size(); c0 = cyc_t;
        db[1] = 1'b1; step(1);
        db[1] = 1'b0; step(5);
        chk("gc_count", log_q.size() - base, 2);
        chk("gc_press", get_ev(base).code, 0);
        chk("gc_rel_chan", get_ev(base + 1).chan, 1);
        chk("gc_rel_code", get_ev(base + 1).code, 1);
        chk("gc_rel_t", get_ev(base + 1).t - c0, 3);
        chk("gc_ovf", bus.ovf, 0);

        // randomized traffic: light then heavy backpressure
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                for (int i = 0; i < N_BTN; i++)
                    if ($urandom_range(0, 39) == 0) db[i] = ~db[i];
                evt_ready = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                ovf_clr   = ($urandom_range(0, 15) == 0) ? N_BTN'($urandom) : '0;
                rst       = ($urandom_range(0, 999) == 0);
                step(1);
            end
        end
        rst = 1'b0; ovf_clr = '0; evt_ready = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
